fifo_pack: RTL and testbench

Downstream consumer of the team's `sync_fifo`. Pops `DATA_W`-bit elements through the FIFO read port, packs `PACK_N` consecutive elements into one wide word, and presents it on a valid/ready output toward the PE-array input buffers. A compile-time option adds a flush path that emits a zero-padded partial word with a lane-keep mask at tile boundaries.

---
 rtl/fifo_pack.sv | 117 +++++++++++
 tb/tb_fifo_pack.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack.sv
// rtl/fifo_pack.sv - packs PACK_N FIFO elements into one wide valid/ready word
// Optional flush/partial-word path enabled by FIFO_PACK_FLUSH_EN.
module fifo_pack #(
   parameter int DATA_W = 8,
   parameter int PACK_N = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        fifo_rd_data,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   output logic [DATA_W*PACK_N-1:0] out_data,
   output logic [PACK_N-1:0]        out_keep,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic                     busy
);

   localparam int OUT_W = DATA_W * PACK_N;
   localparam int CNT_W = $clog2(PACK_N + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(PACK_N);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              pend;
   logic [OUT_W-1:0]  asm_data;
   logic              out_free;
   logic              full_xfer;
   logic              part_xfer;
   logic [CNT_W:0]    fill;
   logic [OUT_W-1:0]  xfer_data;
   logic [PACK_N-1:0] xfer_keep;

   assign out_free  = !out_valid || out_ready;
   assign full_xfer = (cnt == FULL) && out_free;
   // Count in-flight reads so the assembly register can never overflow.
   assign fill       = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
   assign fifo_rd_en = !rst && (state == RUN) && !fifo_empty && (fill < {1'b0, FULL});
   assign busy       = (cnt != '0) || pend || out_valid || (state == DRAIN);

`ifdef FIFO_PACK_FLUSH_EN
   logic drain_done;

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         RUN: begin
            if (flush) state_nxt = DRAIN;
         end
         DRAIN: begin
            // A full word still waiting goes out as a normal transfer first.
            if (!pend && out_free && (cnt != FULL)) begin
               drain_done = 1'b1;
               state_nxt  = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   assign part_xfer = drain_done && (cnt != '0);
`else
   logic unused_flush;

   assign unused_flush = flush;
   assign state_nxt    = RUN;
   assign part_xfer    = 1'b0;
`endif

   always_comb begin
      xfer_data = asm_data;
      xfer_keep = '1;
`ifdef FIFO_PACK_FLUSH_EN
      if (part_xfer) begin
         for (int i = 0; i < PACK_N; i++) begin
            if (CNT_W'(i) >= cnt) begin
               xfer_data[i*DATA_W +: DATA_W] = '0;
               xfer_keep[i]                  = 1'b0;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         pend      <= 1'b0;
         asm_data  <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= fifo_rd_en;
         for (int i = 0; i < PACK_N; i++) begin
            if (pend && (cnt == CNT_W'(i))) asm_data[i*DATA_W +: DATA_W] <= fifo_rd_data;
         end
         // pend implies cnt < PACK_N, so capture and transfer never coincide.
         if (full_xfer || part_xfer) begin
            out_data  <= xfer_data;
            out_keep  <= xfer_keep;
            out_valid <= 1'b1;
            cnt       <= '0;
         end else begin
            if (pend) cnt <= cnt + CNT_W'(1);
            if (out_valid && out_ready) out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_pack.sv
// tb/tb_fifo_pack.sv - randomized scoreboard bench for fifo_pack
module tb_fifo_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  fifo_rd_data;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic        busy;

   fifo_pack #(.DATA_W(8), .PACK_N(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .out_data     (out_data),
      .out_keep     (out_keep),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .flush        (flush),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  fq[$];
   logic [7:0]  log_q[$];
   int          bq[$];
   int          cons = 0;
   int          popped = 0;
   int          nwords = 0;
   int          vcycles = 0;
   int          ready_pct = 100;
   bit          gap_en = 0;
   bit          flush_req = 0;
   logic [31:0] last_word;
   logic [3:0]  last_keep;
   logic [31:0] seen[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_len();
      while (bq.size() > 0 && bq[0] <= cons) void'(bq.pop_front());
      if (bq.size() > 0 && (bq[0] - cons) < 4) return bq[0] - cons;
      return 4;
   endfunction

   task automatic cycle();
      logic [7:0]  d;
      bit          pop;
      int          len;
      logic [31:0] ew;
      logic [3:0]  ek;
      d = 8'h00;
      @(negedge clk);
      out_ready  = ($urandom_range(0, 99) < ready_pct);
      flush      = flush_req;
      flush_req  = 0;
      fifo_empty = (fq.size() == 0) || (gap_en && $urandom_range(0, 1) == 1);
      #1;
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 0);
      pop = fifo_rd_en;
      if (pop) begin
         d = fq.pop_front();
         log_q.push_back(d);
         popped++;
      end
`ifdef FIFO_PACK_FLUSH_EN
      if (flush) bq.push_back(popped);
`endif
      if (out_valid) begin
         vcycles++;
         len = exp_len();
         if (log_q.size() < cons + len) begin
            chk("word_source", log_q.size(), cons + len);
         end else begin
            ew = '0;
            for (int i = 0; i < len; i++) ew[i*8 +: 8] = log_q[cons + i];
            ek = 4'((1 << len) - 1);
            chk("out_data", out_data, ew);
            chk("out_keep", out_keep, ek);
            if (out_ready) begin
               cons += len;
               nwords++;
               last_word = out_data;
               last_keep = out_keep;
               seen.push_back(out_data);
            end
         end
      end
      @(posedge clk);
      #1;
      if (pop) fifo_rd_data = d;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((fq.size() != 0 || busy) && k < budget) begin
         cycle();
         k++;
      end
      chk("idle_timeout", (k < budget), 1);
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_keep", out_keep, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_busy", busy, 0);
      log_q.delete();
      bq.delete();
      cons   = 0;
      popped = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int p;
      int c;
      int n;
      logic [31:0] ew;
      rst          = 1'b1;
      fifo_empty   = 1'b1;
      out_ready    = 1'b0;
      flush        = 1'b0;
      fifo_rd_data = 8'h00;
      #3;
      chk("init_out_valid", out_valid, 0);
      chk("init_out_data", out_data, 0);
      chk("init_out_keep", out_keep, 0);
      chk("init_rd_en", fifo_rd_en, 0);
      chk("init_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;

      // basic packing
      for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
      ready_pct = 100;
      w = nwords;
      vcycles = 0;
      seen.delete();
      repeat (20) cycle();
      chk("basic_words", nwords - w, 2);
      chk("basic_valid_cycles", vcycles, 2);
      if (seen.size() >= 2) begin
         chk("basic_word0", seen[0], 32'h04030201);
         chk("basic_word1", seen[1], 32'h08070605);
      end else begin
         chk("basic_seen", seen.size(), 2);
      end

      // backpressure
      ready_pct = 0;
      p = popped;
      w = nwords;
      for (int i = 0; i < 12; i++) fq.push_back(8'($urandom));
      repeat (20) cycle();
      chk("bp_pops", popped - p, 8);
      chk("bp_rd_en_low", fifo_rd_en, 0);
      chk("bp_no_words", nwords - w, 0);
      ready_pct = 100;
      wait_idle(100);
      chk("bp_drain_words", nwords - w, 3);

      // empty gaps
      gap_en    = 1;
      ready_pct = 60;
      c = cons;
      for (int i = 0; i < 64; i++) fq.push_back(8'($urandom));
      wait_idle(2000);
      chk("gap_all_elements", cons - c, 64);
      gap_en    = 0;
      ready_pct = 100;

`ifdef FIFO_PACK_FLUSH_EN
      fq.push_back(8'hAA);
      fq.push_back(8'hBB);
      repeat (6) cycle();
      w = nwords;
      flush_req = 1;
      wait_idle(50);
      chk("flush_words", nwords - w, 1);
      chk("flush_data", last_word, 32'h0000BBAA);
      chk("flush_keep", last_keep, 4'h3);
      chk("flush_busy", busy, 0);
      w = nwords;
      flush_req = 1;
      repeat (10) cycle();
      chk("flush_empty_words", nwords - w, 0);
      chk("flush_empty_busy", busy, 0);
`else
      fq.push_back(8'hAA);
      fq.push_back(8'hBB);
      repeat (6) cycle();
      w = nwords;
      flush_req = 1;
      repeat (10) cycle();
      chk("noflush_words", nwords - w, 0);
      chk("noflush_busy", busy, 1);
      fq.push_back(8'hCC);
      fq.push_back(8'hDD);
      wait_idle(50);
      chk("noflush_late_words", nwords - w, 1);
      chk("noflush_data", last_word, 32'hDDCCBBAA);
      chk("noflush_keep", last_keep, 4'hF);
`endif

      // reset mid-word: one word held, three lanes filled
      ready_pct = 0;
      for (int i = 0; i < 7; i++) fq.push_back(8'h10 + 8'(i));
      repeat (15) cycle();
      chk("pre_rst_valid", out_valid, 1);
      pulse_reset();
      for (int i = 0; i < 4; i++) fq.push_back(8'h60 + 8'(i));
      ready_pct = 100;
      w = nwords;
      wait_idle(100);
      chk("post_rst_words", nwords - w, 1);
      chk("post_rst_data", last_word, 32'h63626160);

      // randomized segments
      for (int s = 0; s < 12; s++) begin
         gap_en    = ($urandom_range(0, 1) == 1);
         ready_pct = $urandom_range(30, 100);
`ifdef FIFO_PACK_FLUSH_EN
         n = $urandom_range(1, 11);
`else
         n = 4 * $urandom_range(1, 3);
`endif
         for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
         repeat ($urandom_range(0, 12)) cycle();
`ifdef FIFO_PACK_FLUSH_EN
         flush_req = 1;
`endif
         wait_idle(500);
      end
      chk("final_all_consumed", cons, popped);
      chk("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
